// File: rtl/joy_filt_pkg.sv
// Shared mode encodings, direction bit positions and helpers for the
// joystick direction filter.
package joy_filt_pkg;

  typedef enum logic [1:0] {
    JF_PASS   = 2'd0,
    JF_NEWEST = 2'd1,
    JF_HOLD   = 2'd2,
    JF_OFF    = 2'd3
  } jf_mode_e;

  localparam int JF_UP    = 3;
  localparam int JF_DOWN  = 2;
  localparam int JF_LEFT  = 1;
  localparam int JF_RIGHT = 0;

  // Priority order up > down > left > right when several bits compete.
  function automatic logic [3:0] onehot_hi(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    if (v[JF_UP])         r[JF_UP]    = 1'b1;
    else if (v[JF_DOWN])  r[JF_DOWN]  = 1'b1;
    else if (v[JF_LEFT])  r[JF_LEFT]  = 1'b1;
    else if (v[JF_RIGHT]) r[JF_RIGHT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/joy_dir_chan.sv
// One joystick channel: two-flop synchroniser, per-bit debounce, run-time
// direction mode filtering and a one-cycle change strobe.
module joy_dir_chan
  import joy_filt_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] dir_i,
  input  logic [1:0] mode_i,
  output logic [3:0] dir_o,
  output logic       chg_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       db_q, db_d, dbdly_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       out_q, out_d;
  logic [1:0]       mode_q;
  logic             chg_q;
  logic [3:0]       new_w;
  jf_mode_e         mode_w;

  assign mode_w = jf_mode_e'(mode_i);
  assign new_w  = db_q & ~dbdly_q;

  // A bit only flips after sync2 disagrees with it for DB_CYCLES samples in a row.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      db_d[b]  = db_q[b];
      cnt_d[b] = '0;
      if (sync2_q[b] != db_q[b]) begin
        if (cnt_q[b] == CNT_MAX) begin
          db_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    mask_d = 4'b1111;
    out_d  = '0;
    case (mode_w)
      JF_PASS: begin
        out_d = db_q;
        if (db_q[JF_UP] && db_q[JF_DOWN]) begin
          out_d[JF_UP]   = 1'b0;
          out_d[JF_DOWN] = 1'b0;
        end
        if (db_q[JF_LEFT] && db_q[JF_RIGHT]) begin
          out_d[JF_LEFT]  = 1'b0;
          out_d[JF_RIGHT] = 1'b0;
        end
      end
      JF_NEWEST: begin
        mask_d = (new_w != 4'b0000) ? onehot_hi(new_w) : mask_q;
        if ((db_q & mask_d) == 4'b0000) mask_d = 4'b1111;
      end
      JF_HOLD: begin
        mask_d = (mask_q == 4'b1111 && db_q != 4'b0000) ? onehot_hi(db_q) : mask_q;
        if ((db_q & mask_d) == 4'b0000) mask_d = 4'b1111;
      end
      JF_OFF: begin
        out_d = '0;
      end
      default: begin
        out_d = '0;
      end
    endcase
    // A mode switch reopens the mask for one cycle so no stale selection survives.
    if (mode_i != mode_q) mask_d = 4'b1111;
    if (mode_w == JF_NEWEST || mode_w == JF_HOLD) out_d = db_q & mask_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dbdly_q <= '0;
      for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
      mask_q  <= 4'b1111;
      mode_q  <= '0;
      out_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= dir_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbdly_q <= db_q;
      for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
      mask_q  <= mask_d;
      mode_q  <= mode_i;
      out_q   <= out_d;
      chg_q   <= (out_d != out_q);
    end
  end

  assign dir_o = out_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-channel joystick direction conditioner; each channel is an
// independent joy_dir_chan, the top only slices the buses.
module joy_dir_filter #(
  parameter int NUM_CH    = 2,
  parameter int DB_CYCLES = 4,
  localparam int CNT_W    = $clog2(DB_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4*NUM_CH-1:0] dir_in,
  input  logic [2*NUM_CH-1:0] mode,
  output logic [4*NUM_CH-1:0] dir_out,
  output logic [NUM_CH-1:0]   dir_chg
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    joy_dir_chan #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .dir_i  (dir_in[4*c +: 4]),
      .mode_i (mode[2*c +: 2]),
      .dir_o  (dir_out[4*c +: 4]),
      .chg_o  (dir_chg[c])
    );
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: directed table, corner sequences and random
// stimulus checked every cycle against a window-based reference model.
module tb_joy_dir_filter;

  localparam int NCH = 2;
  localparam int DB  = 4;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [4*NCH-1:0] dir_in  = '1;
  logic [2*NCH-1:0] mode    = '0;
  logic [4*NCH-1:0] dir_out;
  logic [NCH-1:0]   dir_chg;

  int n_cmp = 0;
  int n_bad = 0;

  joy_dir_filter #(.NUM_CH(NCH), .DB_CYCLES(DB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .dir_in (dir_in),
    .mode   (mode),
    .dir_out(dir_out),
    .dir_chg(dir_chg)
  );

  always #5 clk = ~clk;

  // Reference model state per channel; debounce judged from a window of samples.
  typedef struct {
    logic [3:0]      s1, s2, db, dbd, mask, out;
    logic [1:0]      mq;
    logic            chg;
    logic [4*DB-1:0] hist;
    int              fill;
  } ch_t;

  ch_t m [NCH];

  function automatic ch_t ch_reset();
    ch_t r;
    r.s1 = '0; r.s2 = '0; r.db = '0; r.dbd = '0;
    r.mask = 4'hF; r.out = '0; r.mq = '0; r.chg = 1'b0;
    r.hist = '0; r.fill = 0;
    return r;
  endfunction

  function automatic logic [3:0] hi1(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  function automatic ch_t step(input ch_t s, input logic [3:0] din, input logic [1:0] md);
    ch_t n;
    logic [3:0] newb, nm, no;
    logic flip;
    n = s;
    n.hist = {s.hist[4*DB-5:0], s.s2};
    if (s.fill < DB) n.fill = s.fill + 1;
    for (int b = 0; b < 4; b++) begin
      if (n.fill == DB) begin
        flip = 1'b1;
        for (int i = 0; i < DB; i++) if (n.hist[4*i+b] == s.db[b]) flip = 1'b0;
        if (flip) n.db[b] = ~s.db[b];
      end
    end
    n.s1 = din;
    n.s2 = s.s1;
    n.dbd = s.db;
    newb = s.db & ~s.dbd;
    nm = 4'hF;
    no = 4'h0;
    if (md == 2'd0) begin
      no = s.db;
      if (s.db[3] && s.db[2]) no[3:2] = 2'b00;
      if (s.db[1] && s.db[0]) no[1:0] = 2'b00;
    end else if (md == 2'd1 || md == 2'd2) begin
      if (md == 2'd1) nm = (newb != 0) ? hi1(newb) : s.mask;
      else            nm = (s.mask == 4'hF && s.db != 0) ? hi1(s.db) : s.mask;
      if ((s.db & nm) == 0) nm = 4'hF;
      if (md != s.mq) nm = 4'hF;
      no = s.db & nm;
    end
    n.mask = nm;
    n.out  = no;
    n.chg  = (no != s.out);
    n.mq   = md;
    return n;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    for (int c = 0; c < NCH; c++) begin
      if (!reset_n) m[c] = ch_reset();
      else          m[c] = step(m[c], dir_in[4*c +: 4], mode[2*c +: 2]);
    end
  end

  initial begin : model_check
    logic [4*NCH-1:0] eo;
    logic [NCH-1:0]   ec;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        eo[4*c +: 4] = m[c].out;
        ec[c]        = m[c].chg;
      end
      n_cmp++;
      if (dir_out !== eo || dir_chg !== ec) begin
        n_bad++;
        $display("FAIL model t=%0t dir_out=%h dir_chg=%b want dir_out=%h dir_chg=%b",
                 $time, dir_out, dir_chg, eo, ec);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [3:0] md;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [7];
  int   hc  [NCH];
  logic both;

  initial begin
    // {ch1,ch0} directions, {ch1,ch0} modes, expected {ch1,ch0} outputs
    tbl[0] = '{din: 8'hCF, md: 4'b0011, exp: 8'h00};
    tbl[1] = '{din: 8'hE5, md: 4'b0011, exp: 8'h20};
    tbl[2] = '{din: 8'h98, md: 4'b0011, exp: 8'h90};
    tbl[3] = '{din: 8'h31, md: 4'b0011, exp: 8'h00};
    tbl[4] = '{din: 8'h6F, md: 4'b0011, exp: 8'h60};
    tbl[5] = '{din: 8'h00, md: 4'b1001, exp: 8'h00};
    tbl[6] = '{din: 8'hA5, md: 4'b1001, exp: 8'h84};

    // Reset with everything pressed
    hold(3);
    chk("rst_out", dir_out, 8'h00);
    chk("rst_chg", 8'(dir_chg), 8'h00);
    dir_in = '0;
    mode   = 4'b0001;
    hold(3);
    reset_n = 1'b1;
    hold(8);

    // Press-to-output latency
    dir_in[3:0] = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("lat_pre", 8'(dir_out[3:0]), 8'h00);
    end
    @(negedge clk);
    chk("lat_out", 8'(dir_out[3:0]), 8'h01);
    chk("lat_chg", 8'(dir_chg[0]), 8'h01);
    @(negedge clk);
    chk("lat_chg_clr", 8'(dir_chg[0]), 8'h00);

    // Debounce: 3-cycle pulse rejected, 4-cycle pulse accepted
    dir_in[3:0] = 4'b0000;
    hold(10);
    dir_in[3:0] = 4'b1000;
    hold(3);
    dir_in[3:0] = 4'b0000;
    both = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (dir_out[3:0] != 4'b0000) both = 1'b1;
    end
    chk("db_short_rejected", 8'(both), 8'h00);
    dir_in[3:0] = 4'b1000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("db_long_pulse", 8'(dir_out[3:0]), (k >= 7 && k <= 10) ? 8'h08 : 8'h00);
      if (k == 4) dir_in[3:0] = 4'b0000;
    end

    // NEWEST on ch0
    dir_in[3:0] = 4'b0010;
    hold(10);
    chk("newest_left", 8'(dir_out[3:0]), 8'h02);
    dir_in[3:0] = 4'b1010;
    both = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dir_out[3:0] == 4'b1010) both = 1'b1;
    end
    chk("newest_up", 8'(dir_out[3:0]), 8'h08);
    chk("newest_never_two", 8'(both), 8'h00);
    dir_in[3:0] = 4'b0010;
    hold(10);
    chk("newest_rel_up", 8'(dir_out[3:0]), 8'h02);
    dir_in[3:0] = 4'b0000;
    hold(10);
    chk("newest_rel_all", 8'(dir_out[3:0]), 8'h00);
    dir_in[3:0] = 4'b0101;
    hold(10);
    chk("newest_simul", 8'(dir_out[3:0]), 8'h04);

    // HOLD_FIRST on ch0
    dir_in[3:0] = 4'b0000;
    mode[1:0]   = 2'd2;
    hold(10);
    dir_in[3:0] = 4'b0010;
    hold(10);
    chk("hold_left", 8'(dir_out[3:0]), 8'h02);
    dir_in[3:0] = 4'b1010;
    hold(10);
    chk("hold_keeps_first", 8'(dir_out[3:0]), 8'h02);
    dir_in[3:0] = 4'b1000;
    hold(10);
    chk("hold_rel_first", 8'(dir_out[3:0]), 8'h08);

    // Table: PASS/SOCD, OFF and simultaneous presses
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dir_in = tbl[i].din;
      mode   = tbl[i].md;
      hold(12);
      chk($sformatf("table_%0d", i), dir_out, tbl[i].exp);
    end

    // Mode switch mid-hold, NEWEST -> HOLD_FIRST on ch0
    dir_in[3:0] = 4'b0000;
    hold(10);
    dir_in[3:0] = 4'b0010;
    hold(10);
    dir_in[3:0] = 4'b1010;
    hold(10);
    chk("sw_before", 8'(dir_out[3:0]), 8'h08);
    mode[1:0] = 2'd2;
    @(negedge clk);
    chk("sw_open", 8'(dir_out[3:0]), 8'h0A);
    @(negedge clk);
    chk("sw_after", 8'(dir_out[3:0]), 8'h08);

    // Asynchronous reset mid-hold
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", dir_out, 8'h00);
    chk("arst_chg", 8'(dir_chg), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("arst_recover_pre", 8'(dir_out[3:0]), 8'h00);
    end
    @(negedge clk);
    chk("arst_recover", 8'(dir_out[3:0]), 8'h08);

    // Random stimulus, checked by the model every cycle
    for (int c = 0; c < NCH; c++) hc[c] = 0;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (hc[c] == 0) begin
          dir_in[4*c +: 4] = 4'($urandom);
          hc[c] = $urandom_range(1, 9);
        end else begin
          hc[c]--;
        end
      end
      if ($urandom_range(0, 63) == 0) mode[2*$urandom_range(0, NCH-1) +: 2] = 2'($urandom);
      if (it == 1500) begin
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    hold(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
